// File: rtl/avgpool_channel_sequencer_pkg.sv
// pool_pkg: shared definitions for the pooling/conv channel sequencers.
//   state_t / S_* : sequencer FSM state encoding (legacy-compatible constants)
//   pix_per_map() : pixels (and results) per feature map, W*H
package pool_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_CLEAR = 3'd1;
  localparam state_t S_FEED  = 3'd2;
  localparam state_t S_DRAIN = 3'd3;
  localparam state_t S_NEXT  = 3'd4;
  localparam state_t S_DONE  = 3'd5;

  function automatic int pix_per_map(input int w, input int h);
    return w * h;
  endfunction

endpackage

// File: rtl/avgpool_channel_sequencer_if.sv
// Pixel/result bus between the channel sequencer and its environment.
//   Input FIFO  : In_Data, In_Empty (to sequencer), In_RD (from sequencer)
//   Pool engine : Pool_In, Pool_Valid_IN, Pool_CLR (from sequencer),
//                 Pool_Out, Pool_Valid_OUT (to sequencer)
//   Output FIFO : Out_Data, Out_WR (from sequencer), Out_Almost_Full (to sequencer)
// master = sequencer side, slave = FIFOs/engine side.
interface avgpool_channel_sequencer_if
  import pool_pkg::*;
#(
  parameter int Datawidth = 16
);
  logic [Datawidth-1:0] In_Data;
  logic                 In_Empty;
  logic                 In_RD;
  logic [Datawidth-1:0] Pool_In;
  logic                 Pool_Valid_IN;
  logic                 Pool_CLR;
  logic [Datawidth-1:0] Pool_Out;
  logic                 Pool_Valid_OUT;
  logic [Datawidth-1:0] Out_Data;
  logic                 Out_WR;
  logic                 Out_Almost_Full;

  modport master (
    input  In_Data, In_Empty, Pool_Out, Pool_Valid_OUT, Out_Almost_Full,
    output In_RD, Pool_In, Pool_Valid_IN, Pool_CLR, Out_Data, Out_WR
  );

  modport slave (
    output In_Data, In_Empty, Pool_Out, Pool_Valid_OUT, Out_Almost_Full,
    input  In_RD, Pool_In, Pool_Valid_IN, Pool_CLR, Out_Data, Out_WR
  );
endinterface

// File: rtl/avgpool_channel_sequencer_result_collector.sv
// pool_result_collector: moves engine results into the output FIFO.
//   CLK, CLR         : clock, async active-high reset
//   clear            : zero the result counter (between channels)
//   enable           : results are accepted only while high (FEED/DRAIN)
//   pool_out/_valid  : engine result stream
//   out_almost_full  : output FIFO nearly full; a write while high sets ovf_err
//   out_data, out_wr : registered output FIFO write port
//   res_cnt          : results written for the current channel
//   ovf_err          : sticky, a result was written into an almost-full FIFO
// Results beyond Pix_Per_Map per channel are engine drain artefacts and dropped.
module pool_result_collector
  import pool_pkg::*;
#(
  parameter  int Datawidth   = 16,
  parameter  int Pix_Per_Map = 49,
  localparam int CNT_W       = $clog2(Pix_Per_Map + 1)
) (
  input  logic                 CLK,
  input  logic                 CLR,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [Datawidth-1:0] pool_out,
  input  logic                 pool_valid_out,
  input  logic                 out_almost_full,
  output logic [Datawidth-1:0] out_data,
  output logic                 out_wr,
  output logic [CNT_W-1:0]     res_cnt,
  output logic                 ovf_err
);

  localparam logic [CNT_W-1:0] PIX_C = CNT_W'(Pix_Per_Map);

  logic accept;

  always_comb begin
    accept = enable & pool_valid_out & (res_cnt < PIX_C);
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      res_cnt  <= '0;
      out_wr   <= 1'b0;
      out_data <= '0;
      ovf_err  <= 1'b0;
    end else begin
      out_wr <= 1'b0;
      if (clear) begin
        res_cnt <= '0;
      end else if (accept) begin
        out_wr   <= 1'b1;
        out_data <= pool_out;
        res_cnt  <= res_cnt + 1'b1;
        // Never dropped: the FIFO's almost-full margin absorbs it, but flag it.
        if (out_almost_full) begin
          ovf_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/avgpool_channel_sequencer.sv
// avgpool_channel_sequencer: runs one streaming 7x7 average-pool engine over
// Channels feature maps of IMG_Width x IMG_Height per Start.
//   CLK, CLR     : clock, async active-high reset (aborts any run, no Done)
//   Start        : pulse, accepted in IDLE only
//   Busy         : high in every state except IDLE
//   Done         : one-cycle pulse after the last channel
//   Channel_Idx  : channel in progress
//   Err          : sticky drain timeout / result written while almost full
//   bus          : input FIFO, pool engine and output FIFO signals (master)
// Per channel: CLEAR (engine clear) -> FEED (W*H pixels from the FIFO) ->
// DRAIN (zero pixels until W*H results are collected) -> NEXT.
module avgpool_channel_sequencer
  import pool_pkg::*;
#(
  parameter  int IMG_Width    = 7,
  parameter  int IMG_Height   = 7,
  parameter  int Datawidth    = 16,
  parameter  int Channels     = 64,
  parameter  int Clear_Cycles = 2,
  parameter  int Drain_Limit  = IMG_Width * 3 + 8,
  localparam int CH_W         = (Channels > 1) ? $clog2(Channels) : 1
) (
  input  logic                           CLK,
  input  logic                           CLR,
  input  logic                           Start,
  output logic                           Busy,
  output logic                           Done,
  output logic [CH_W-1:0]                Channel_Idx,
  output logic                           Err,
  avgpool_channel_sequencer_if.master    bus
);

  localparam int PIX   = pix_per_map(IMG_Width, IMG_Height);
  localparam int CNT_W = $clog2(PIX + 1);
  localparam int DRN_W = $clog2(Drain_Limit + 1);
  localparam int CLR_W = (Clear_Cycles > 1) ? $clog2(Clear_Cycles) : 1;

  localparam logic [CNT_W-1:0] PIX_C    = CNT_W'(PIX);
  localparam logic [DRN_W-1:0] DRN_C    = DRN_W'(Drain_Limit);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(Clear_Cycles - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(Channels - 1);

  state_t               state;
  logic [CLR_W-1:0]     clr_cnt;
  logic [CNT_W-1:0]     rd_cnt;
  logic [CNT_W-1:0]     pix_cnt;
  logic [CNT_W-1:0]     res_cnt;
  logic [DRN_W-1:0]     drain_cnt;
  logic                 rd_pend;
  logic                 feed_valid_q;
  logic [Datawidth-1:0] feed_data_q;
  logic                 drain_err;
  logic                 ovf_err;

  logic in_feed;
  logic in_drain;
  logic rd_en;
  logic drain_px;
  logic feed_done;
  logic drain_timeout;

  always_comb begin
    in_feed       = (state == S_FEED);
    in_drain      = (state == S_DRAIN);
    rd_en         = in_feed & ~bus.In_Empty & ~bus.Out_Almost_Full & (rd_cnt < PIX_C);
    drain_px      = in_drain & ~bus.Out_Almost_Full & (drain_cnt < DRN_C);
    // pix_cnt lags Pool_Valid_IN by a cycle, so reaching W*H means the last
    // read has already been presented to the engine.
    feed_done     = (pix_cnt == PIX_C) & ~rd_pend & ~feed_valid_q;
    drain_timeout = (drain_cnt == DRN_C) & (res_cnt < PIX_C);
  end

  // Feed pixels come from the 2-stage read pipeline; drain pixels are
  // combinational so none leak out once DRAIN is left.
  assign bus.In_RD         = rd_en;
  assign bus.Pool_Valid_IN = feed_valid_q | drain_px;
  assign bus.Pool_In       = drain_px ? '0 : feed_data_q;
  assign bus.Pool_CLR      = ~(in_feed | in_drain);

  assign Busy = (state != S_IDLE);
  assign Done = (state == S_DONE);
  assign Err  = drain_err | ovf_err;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state       <= S_IDLE;
      Channel_Idx <= '0;
      clr_cnt     <= '0;
      drain_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            Channel_Idx <= '0;
            clr_cnt     <= '0;
            state       <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (clr_cnt == CLR_LAST) begin
            state <= S_FEED;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        S_FEED: begin
          if (feed_done) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (res_cnt == PIX_C) begin
            state <= S_NEXT;
          end else if (drain_timeout) begin
            drain_err <= 1'b1;
            state     <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (Channel_Idx == CH_LAST) begin
            state <= S_DONE;
          end else begin
            Channel_Idx <= Channel_Idx + 1'b1;
            clr_cnt     <= '0;
            state       <= S_CLEAR;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      rd_cnt       <= '0;
      pix_cnt      <= '0;
      drain_cnt    <= '0;
      rd_pend      <= 1'b0;
      feed_valid_q <= 1'b0;
      feed_data_q  <= '0;
    end else if (state == S_CLEAR) begin
      rd_cnt       <= '0;
      pix_cnt      <= '0;
      drain_cnt    <= '0;
      rd_pend      <= 1'b0;
      feed_valid_q <= 1'b0;
    end else begin
      rd_pend      <= rd_en;
      feed_valid_q <= rd_pend;
      if (rd_en) begin
        rd_cnt <= rd_cnt + 1'b1;
      end
      if (rd_pend) begin
        feed_data_q <= bus.In_Data;
      end
      if (feed_valid_q) begin
        pix_cnt <= pix_cnt + 1'b1;
      end
      if (drain_px) begin
        drain_cnt <= drain_cnt + 1'b1;
      end
    end
  end

  pool_result_collector #(
    .Datawidth   (Datawidth),
    .Pix_Per_Map (PIX)
  ) u_collector (
    .CLK             (CLK),
    .CLR             (CLR),
    .clear           (state == S_CLEAR),
    .enable          (in_feed | in_drain),
    .pool_out        (bus.Pool_Out),
    .pool_valid_out  (bus.Pool_Valid_OUT),
    .out_almost_full (bus.Out_Almost_Full),
    .out_data        (bus.Out_Data),
    .out_wr          (bus.Out_WR),
    .res_cnt         (res_cnt),
    .ovf_err         (ovf_err)
  );

endmodule

// File: tb/tb_avgpool_channel_sequencer.sv
// Directed bench for avgpool_channel_sequencer (7x7 maps, 2 channels) with an
// input FIFO model, a behavioural 7x7 padded average-pool engine and an
// output capture queue.
module tb_avgpool_channel_sequencer;

  localparam int W     = 7;
  localparam int H     = 7;
  localparam int DW    = 16;
  localparam int CH    = 2;
  localparam int PIX   = W * H;
  localparam int DRAIN = W * 3 + 8;

  logic       CLK = 1'b0;
  logic       CLR;
  logic       Start;
  logic       Busy;
  logic       Done;
  logic [0:0] Channel_Idx;
  logic       Err;

  avgpool_channel_sequencer_if #(.Datawidth(DW)) bus ();

  avgpool_channel_sequencer #(
    .IMG_Width    (W),
    .IMG_Height   (H),
    .Datawidth    (DW),
    .Channels     (CH),
    .Clear_Cycles (2),
    .Drain_Limit  (DRAIN)
  ) dut (
    .CLK         (CLK),
    .CLR         (CLR),
    .Start       (Start),
    .Busy        (Busy),
    .Done        (Done),
    .Channel_Idx (Channel_Idx),
    .Err         (Err),
    .bus         (bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Padded 7x7 window sum / 49 with ReLU, result index k in raster order.
  function automatic int golden(input int m[PIX], input int k);
    int r, c, s;
    r = k / W;
    c = k % W;
    s = 0;
    for (int dr = -3; dr <= 3; dr++) begin
      for (int dc = -3; dc <= 3; dc++) begin
        if (r + dr >= 0 && r + dr < H && c + dc >= 0 && c + dc < W) begin
          s += m[(r + dr) * W + (c + dc)];
        end
      end
    end
    if (s < 0) s = 0;
    return s / 49;
  endfunction

  // Stream position of the last pixel a result needs (line-buffer lookahead).
  function automatic int need(input int k);
    return (k / W + 3) * W + (k % W + 3);
  endfunction

  // ---------------- input FIFO model ----------------
  int in_q[$];
  bit rand_empty = 1'b0;
  bit fifo_rd;

  always @(posedge CLK) begin
    fifo_rd = bus.In_RD;
    #1;
    if (fifo_rd && in_q.size() != 0) bus.In_Data = DW'(in_q.pop_front());
    bus.In_Empty = (in_q.size() == 0) || (rand_empty && $urandom_range(0, 1) == 1);
  end

  // ---------------- engine model ----------------
  int         epix[PIX];
  int         e_n = 0;
  int         e_k = 0;
  bit         withhold = 1'b0;
  bit         e_v, e_clr;
  logic [DW-1:0] e_d;

  always @(posedge CLK) begin
    e_v   = bus.Pool_Valid_IN;
    e_d   = bus.Pool_In;
    e_clr = bus.Pool_CLR;
    #1;
    bus.Pool_Valid_OUT = 1'b0;
    if (e_clr) begin
      e_n = 0;
      e_k = 0;
    end else begin
      if (e_v) begin
        if (e_n < PIX) epix[e_n] = int'($signed(e_d));
        e_n++;
      end
      if (e_k < PIX && e_n > need(e_k) &&
          !(withhold && Channel_Idx == 1'b0 && e_k == PIX - 1)) begin
        bus.Pool_Out       = DW'(golden(epix, e_k));
        bus.Pool_Valid_OUT = 1'b1;
        e_k++;
      end
    end
  end

  // ---------------- monitor (sampled on negedge) ----------------
  logic [DW-1:0] out_q[$];
  int rd_seen = 0, rd_empty_viol = 0, done_cnt = 0;
  bit hold_win = 0, hold_late = 0;
  int hold_rd = 0, hold_vin = 0;

  always @(negedge CLK) begin
    if (bus.Out_WR) out_q.push_back(bus.Out_Data);
    if (bus.In_RD) rd_seen++;
    if (bus.In_RD && bus.In_Empty) rd_empty_viol++;
    if (Done) done_cnt++;
    if (hold_win && bus.In_RD) hold_rd++;
    if (hold_late && bus.Pool_Valid_IN) hold_vin++;
  end

  // ---------------- stimulus helpers ----------------
  int exp_map[CH][PIX];

  task automatic reset_dut();
    CLR = 1'b1;
    Start = 1'b0;
    bus.Out_Almost_Full = 1'b0;
    rand_empty = 1'b0;
    withhold = 1'b0;
    in_q.delete();
    repeat (3) @(negedge CLK);
    CLR = 1'b0;
    @(negedge CLK);
    out_q.delete();
    rd_seen = 0;
    rd_empty_viol = 0;
    done_cnt = 0;
  endtask

  task automatic load_ramp();
    for (int ch = 0; ch < CH; ch++)
      for (int i = 0; i < PIX; i++) begin
        exp_map[ch][i] = ch * PIX + i + 1;
        in_q.push_back(exp_map[ch][i]);
      end
  endtask

  task automatic load_const(input int v);
    for (int ch = 0; ch < CH; ch++)
      for (int i = 0; i < PIX; i++) begin
        exp_map[ch][i] = v;
        in_q.push_back(v);
      end
  endtask

  task automatic start_run(output int lat);
    @(negedge CLK);
    Start = 1'b1;
    lat = 0;
    do begin
      @(negedge CLK);
      Start = 1'b0;
      lat++;
    end while (!bus.Pool_Valid_IN && lat < 100);
  endtask

  task automatic wait_done(input string tag);
    int d0, cyc;
    d0 = done_cnt;
    cyc = 0;
    while (done_cnt == d0 && cyc < 3000) begin
      @(negedge CLK);
      cyc++;
    end
    check_val({tag, "_done_seen"}, 32'(done_cnt != d0), 1);
    @(negedge CLK);
    check_val({tag, "_busy_after"}, 32'(Busy), 0);
  endtask

  task automatic check_outputs(input string tag, input bit miss_last0);
    logic [DW-1:0] exp_q[$];
    for (int ch = 0; ch < CH; ch++)
      for (int k = 0; k < PIX; k++)
        if (!(miss_last0 && ch == 0 && k == PIX - 1))
          exp_q.push_back(DW'(golden(exp_map[ch], k)));
    check_val({tag, "_nres"}, out_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
      check_val($sformatf("%s_res%0d", tag, i), 32'(out_q[i]), 32'(exp_q[i]));
  endtask

  int lat;
  int d_before;

  initial begin
    // reset state
    CLR = 1'b1;
    Start = 1'b0;
    bus.Out_Almost_Full = 1'b0;
    repeat (3) @(negedge CLK);
    check_val("rst_busy", 32'(Busy), 0);
    check_val("rst_done", 32'(Done), 0);
    check_val("rst_chidx", 32'(Channel_Idx), 0);
    check_val("rst_in_rd", 32'(bus.In_RD), 0);
    check_val("rst_vin", 32'(bus.Pool_Valid_IN), 0);
    check_val("rst_pool_in", 32'(bus.Pool_In), 0);
    check_val("rst_pool_clr", 32'(bus.Pool_CLR), 1);
    check_val("rst_out_wr", 32'(bus.Out_WR), 0);
    check_val("rst_out_data", 32'(bus.Out_Data), 0);
    check_val("rst_err", 32'(Err), 0);

    // 1: ramp over two channels
    reset_dut();
    load_ramp();
    start_run(lat);
    check_val("t1_latency_ge5", 32'(lat >= 5), 1);
    wait_done("t1");
    check_val("t1_reads", rd_seen, 2 * PIX);
    check_val("t1_done_once", done_cnt, 1);
    check_val("t1_err", 32'(Err), 0);
    check_outputs("t1", 1'b0);
    if (out_q.size() > PIX + 24) begin
      check_val("t1_corner", 32'(out_q[0]), 4);
      check_val("t1_centre", 32'(out_q[24]), 25);
      check_val("t1_ch1_centre", 32'(out_q[PIX + 24]), 74);
    end else begin
      check_val("t1_short_output", out_q.size(), 2 * PIX);
    end

    // 2: constant map of 49
    reset_dut();
    load_const(49);
    start_run(lat);
    wait_done("t2");
    check_outputs("t2", 1'b0);
    if (out_q.size() > 24) begin
      check_val("t2_corner", 32'(out_q[0]), 16);
      check_val("t2_edge_r0c3", 32'(out_q[3]), 28);
      check_val("t2_edge_r3c0", 32'(out_q[21]), 28);
      check_val("t2_r1c1", 32'(out_q[8]), 25);
      check_val("t2_centre", 32'(out_q[24]), 49);
    end else begin
      check_val("t2_short_output", out_q.size(), 2 * PIX);
    end
    check_val("t2_err", 32'(Err), 0);

    // 3: random input-FIFO empties
    reset_dut();
    load_ramp();
    rand_empty = 1'b1;
    start_run(lat);
    wait_done("t3");
    rand_empty = 1'b0;
    check_outputs("t3", 1'b0);
    check_val("t3_rd_while_empty", rd_empty_viol, 0);
    check_val("t3_err", 32'(Err), 0);

    // 4: almost-full hold of 100 cycles early in FEED
    reset_dut();
    load_ramp();
    start_run(lat);
    for (int c = 0; c < 200 && rd_seen < 10; c++) @(negedge CLK);
    check_val("t4_reached_feed", 32'(rd_seen >= 10), 1);
    bus.Out_Almost_Full = 1'b1;
    hold_win = 1'b1;
    hold_rd = 0;
    hold_vin = 0;
    repeat (3) @(negedge CLK);
    hold_late = 1'b1;
    repeat (97) @(negedge CLK);
    hold_win = 1'b0;
    hold_late = 1'b0;
    bus.Out_Almost_Full = 1'b0;
    check_val("t4_rd_in_hold", hold_rd, 0);
    check_val("t4_vin_in_hold", hold_vin, 0);
    wait_done("t4");
    check_outputs("t4", 1'b0);
    check_val("t4_err", 32'(Err), 0);

    // 5: engine never delivers channel 0's last result
    reset_dut();
    load_ramp();
    withhold = 1'b1;
    start_run(lat);
    wait_done("t5");
    check_val("t5_err", 32'(Err), 1);
    check_val("t5_done_once", done_cnt, 1);
    check_outputs("t5", 1'b1);
    withhold = 1'b0;

    // 6: CLR during channel 1 FEED, then restart
    reset_dut();
    load_ramp();
    start_run(lat);
    for (int c = 0; c < 1000 && !(Channel_Idx == 1'b1 && rd_seen >= PIX + 5); c++)
      @(negedge CLK);
    check_val("t6_reached_ch1", 32'(Channel_Idx), 1);
    d_before = done_cnt;
    #2;
    CLR = 1'b1;
    #1;
    check_val("t6_busy", 32'(Busy), 0);
    check_val("t6_pool_clr", 32'(bus.Pool_CLR), 1);
    check_val("t6_in_rd", 32'(bus.In_RD), 0);
    check_val("t6_vin", 32'(bus.Pool_Valid_IN), 0);
    check_val("t6_out_wr", 32'(bus.Out_WR), 0);
    check_val("t6_out_data", 32'(bus.Out_Data), 0);
    check_val("t6_chidx", 32'(Channel_Idx), 0);
    check_val("t6_err", 32'(Err), 0);
    repeat (3) @(negedge CLK);
    CLR = 1'b0;
    repeat (20) @(negedge CLK);
    check_val("t6_no_done", done_cnt - d_before, 0);
    check_val("t6_idle_busy", 32'(Busy), 0);
    in_q.delete();
    load_ramp();
    out_q.delete();
    @(negedge CLK);
    Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    check_val("t6_restart_busy", 32'(Busy), 1);
    check_val("t6_restart_chidx", 32'(Channel_Idx), 0);
    wait_done("t6");
    check_outputs("t6", 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
